// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the load/store unit: opcode values, func3 access-size
// encodings, controller FSM states and the access legality check.
package mem_access_ctrl_pkg;

   // Major opcodes of the instructions that reach the memory access controller
   localparam logic [6:0] OpcLoad  = 7'b0000011;
   localparam logic [6:0] OpcStore = 7'b0100011;

   // func3 access size / signedness
   typedef enum logic [2:0] {
      RwB  = 3'b000,
      RwH  = 3'b001,
      RwW  = 3'b010,
      RwBu = 3'b100,
      RwHu = 3'b101
   } rw_type_e;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } state_e;

   // High when the request can never be issued on the bus: conflicting direction,
   // unknown size, unsigned store, or misaligned half/word.
   function automatic logic access_illegal(input logic       rd,
                                           input logic       wr,
                                           input logic [2:0] rw,
                                           input logic [1:0] off);
      logic ill;
      ill = rd & wr;
      case (rw)
         RwB:     ill = ill;
         RwBu:    ill = ill | wr;
         RwH:     ill = ill | off[0];
         RwHu:    ill = ill | wr | off[0];
         RwW:     ill = ill | (off != 2'b00);
         default: ill = 1'b1;
      endcase
      return ill;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load result formatting: picks the byte/halfword lane of the returned bus word
// and sign- or zero-extends it; words pass straight through.
//   word     - raw 32-bit word from the bus
//   byte_off - low address bits of the access
//   rw_type  - func3 size/signedness
//   result   - formatted 32-bit load value
module mem_load_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  byte_off,
   input  logic [2:0]  rw_type,
   output logic [31:0] result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (byte_off)
         2'd0:    byte_lane = word[7:0];
         2'd1:    byte_lane = word[15:8];
         2'd2:    byte_lane = word[23:16];
         default: byte_lane = word[31:24];
      endcase
      // Halfwords are aligned, so only bit 1 selects the lane
      half_lane = byte_off[1] ? word[31:16] : word[15:0];

      case (rw_type)
         RwB:     result = {{24{byte_lane[7]}}, byte_lane};
         RwBu:    result = {24'h0, byte_lane};
         RwH:     result = {{16{half_lane[15]}}, half_lane};
         RwHu:    result = {16'h0, half_lane};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: turns decoder load/store requests into a single
// req/gnt + rvalid bus transaction, stalling the pipeline until completion.
//   clk, rst                  - clock, synchronous active-high reset
//   memread, memwrite         - load / store request from the decoder
//   rw_type, addr, wdata      - func3 size, byte address, store data
//   stall, done, err, rdata   - pipeline hold, completion pulse, failure flag, load data
//   mem_req .. mem_wdata      - bus request channel
//   mem_gnt, mem_rvalid, mem_rdata - bus response channel
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [2:0]  rw_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

   state_e          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [2:0]      rw_q, rw_d;
   logic            store_q, store_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic            access;
   logic            timeout;
   logic [31:0]     load_data;
   logic [3:0]      strb;
   logic [31:0]     lanes;

   mem_load_align u_load_align (
      .word     (mem_rdata),
      .byte_off (addr_q[1:0]),
      .rw_type  (rw_q),
      .result   (load_data)
   );

   assign access  = memread | memwrite;
   // Last allowed cycle in REQ/WAIT; a handshake in that same cycle still wins
   assign timeout = (cnt_q >= CntW'(TIMEOUT_CYC - 1));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rw_d    = rw_q;
      store_d = store_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (access) begin
               addr_d  = addr;
               wdata_d = wdata;
               rw_d    = rw_type;
               store_d = memwrite;
               rdata_d = '0;
               cnt_d   = '0;
               err_d   = access_illegal(memread, memwrite, rw_type, addr[1:0]);
               state_d = err_d ? StDone : StReq;
            end
         end
         StReq: begin
            cnt_d = cnt_q + CntW'(1);
            if (mem_gnt) begin
               state_d = store_q ? StDone : StWait;
            end else if (timeout) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = StDone;
            end
         end
         StWait: begin
            cnt_d = cnt_q + CntW'(1);
            if (mem_rvalid) begin
               rdata_d = load_data;
               state_d = StDone;
            end else if (timeout) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= '0;
         store_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
         store_q <= store_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // Store byte enables and lane replication from the latched request
   always_comb begin
      case (rw_q)
         RwB: begin
            strb  = 4'b0001 << addr_q[1:0];
            lanes = {4{wdata_q[7:0]}};
         end
         RwH: begin
            strb  = addr_q[1] ? 4'b1100 : 4'b0011;
            lanes = {2{wdata_q[15:0]}};
         end
         default: begin
            strb  = 4'b1111;
            lanes = wdata_q;
         end
      endcase
   end

   always_comb begin
      stall     = ((state_q == StIdle) && access) || (state_q == StReq) || (state_q == StWait);
      done      = (state_q == StDone);
      err       = done & err_q;
      rdata     = rdata_q;
      mem_req   = (state_q == StReq);
      mem_we    = mem_req & store_q;
      mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
      mem_wstrb = mem_we ? strb : 4'b0000;
      mem_wdata = mem_we ? lanes : '0;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a table of accesses with a reactive bus model,
// expected completions scoreboarded in a queue, plus a reset-abort sequence.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst;
   logic        memread, memwrite;
   logic [2:0]  rw_type;
   logic [31:0] addr, wdata;
   logic        stall, done, err;
   logic [31:0] rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [2:0]  rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gnt_dly;   // REQ cycles before gnt, -1 = never
      int          rv_dly;    // WAIT cycles before rvalid, -1 = never
      logic        spur;      // drive a bogus rvalid while in REQ
      logic [31:0] rword;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [3:0]  exp_wstrb;
      logic [31:0] exp_wdata;
      int          exp_stalls;
      logic        exp_req;
   } vec_t;

   typedef struct {
      string       name;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   localparam int NVec = 17;
   vec_t vecs[NVec];
   exp_t exp_q[$];
   exp_t mon_e;

   mem_access_ctrl #(
      .TIMEOUT_CYC (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .memread    (memread),
      .memwrite   (memwrite),
      .rw_type    (rw_type),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .done       (done),
      .err        (err),
      .rdata      (rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse retires the oldest outstanding access
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_done: got done=1 expected no completion");
         end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, "_err"}, {31'h0, err}, {31'h0, mon_e.err});
            chk({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
         end
      end
   end

   // Drive one access from negedge and play the bus side until done
   task automatic run_access(input vec_t v);
      int   stalls = 0;
      int   req_cyc = 0;
      int   wait_cyc = 0;
      logic granted = 1'b0;
      logic req_seen = 1'b0;
      logic fin = 1'b0;
      logic fired;
      logic [31:0] exp_addr;
      exp_addr = {v.addr[31:2], 2'b00};
      exp_q.push_back('{v.name, v.exp_err, v.exp_rdata});
      memread  = v.rd;
      memwrite = v.wr;
      rw_type  = v.rw;
      addr     = v.addr;
      wdata    = v.wdata;
      for (int c = 0; c < 30 && !fin; c++) begin
         #1;
         if (done) begin
            fin = 1'b1;
            chk({v.name, "_stall_in_done"}, {31'h0, stall}, 32'h0);
         end else begin
            if (stall) stalls++;
            if (mem_req) begin
               req_seen = 1'b1;
               chk({v.name, "_mem_addr"}, mem_addr, exp_addr);
               chk({v.name, "_mem_we"}, {31'h0, mem_we}, {31'h0, v.wr});
               if (v.wr) begin
                  chk({v.name, "_mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, v.exp_wstrb});
                  chk({v.name, "_mem_wdata"}, mem_wdata, v.exp_wdata);
               end
               mem_gnt    = (v.gnt_dly >= 0) && (req_cyc == v.gnt_dly);
               mem_rvalid = v.spur;
               mem_rdata  = 32'hFFFF_FFFF;
               req_cyc++;
            end else if (granted) begin
               mem_rvalid = (v.rv_dly >= 0) && (wait_cyc == v.rv_dly);
               mem_rdata  = v.rword;
               wait_cyc++;
            end
         end
         fired = mem_gnt & mem_req;
         @(posedge clk);
         if (fired) granted = 1'b1;
         #1;
         memread    = 1'b0;
         memwrite   = 1'b0;
         mem_gnt    = 1'b0;
         mem_rvalid = 1'b0;
         @(negedge clk);
      end
      if (!fin) begin
         n_chk++;
         n_err++;
         $display("FAIL %s_no_done: got no done within 30 cycles expected done", v.name);
      end
      chk({v.name, "_stalls"}, stalls, v.exp_stalls);
      chk({v.name, "_req_seen"}, {31'h0, req_seen}, {31'h0, v.exp_req});
      @(negedge clk);
      #1;
      chk({v.name, "_done_one_cycle"}, {31'h0, done}, 32'h0);
   endtask

   initial begin
      // name, rd, wr, rw, addr, wdata, gnt, rv, spur, rword,
      // err, rdata, wstrb, wdata_exp, stalls, req
      vecs[0]  = '{"sw_word", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, -1, 0, 0,
                   0, 0, 4'b1111, 32'hDEADBEEF, 2, 1};
      vecs[1]  = '{"lb_sext", 1, 0, 3'b000, 32'h103, 0, 0, 0, 0, 32'h80FF0011,
                   0, 32'hFFFFFF80, 0, 0, 3, 1};
      vecs[2]  = '{"lbu_zext", 1, 0, 3'b100, 32'h103, 0, 0, 0, 0, 32'h80FF0011,
                   0, 32'h00000080, 0, 0, 3, 1};
      vecs[3]  = '{"lh_hi", 1, 0, 3'b001, 32'h102, 0, 0, 0, 0, 32'h80FF0011,
                   0, 32'hFFFF80FF, 0, 0, 3, 1};
      vecs[4]  = '{"lhu_hi", 1, 0, 3'b101, 32'h102, 0, 0, 0, 0, 32'h80FF0011,
                   0, 32'h000080FF, 0, 0, 3, 1};
      vecs[5]  = '{"lh_misal", 1, 0, 3'b001, 32'h101, 0, 0, 0, 0, 0,
                   1, 0, 0, 0, 1, 0};
      vecs[6]  = '{"lw_misal", 1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 0,
                   1, 0, 0, 0, 1, 0};
      vecs[7]  = '{"sh_gnt_late", 0, 1, 3'b001, 32'h22, 32'h1234ABCD, 5, -1, 0, 0,
                   0, 0, 4'b1100, 32'hABCDABCD, 7, 1};
      vecs[8]  = '{"lw_timeout", 1, 0, 3'b010, 32'h200, 0, 0, -1, 0, 0,
                   1, 0, 0, 0, 9, 1};
      vecs[9]  = '{"lw_after_to", 1, 0, 3'b010, 32'h104, 0, 0, 0, 1, 32'h12345678,
                   0, 32'h12345678, 0, 0, 3, 1};
      vecs[10] = '{"sb_lane1", 0, 1, 3'b000, 32'h101, 32'h000000A5, 0, -1, 0, 0,
                   0, 0, 4'b0010, 32'hA5A5A5A5, 2, 1};
      vecs[11] = '{"rd_wr_both", 1, 1, 3'b010, 32'h100, 0, 0, 0, 0, 0,
                   1, 0, 0, 0, 1, 0};
      vecs[12] = '{"rw_bad", 1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0,
                   1, 0, 0, 0, 1, 0};
      vecs[13] = '{"store_bu", 0, 1, 3'b100, 32'h100, 32'h55, 0, -1, 0, 0,
                   1, 0, 0, 0, 1, 0};
      vecs[14] = '{"lh_rv_late", 1, 0, 3'b001, 32'h100, 0, 0, 2, 0, 32'h00008001,
                   0, 32'hFFFF8001, 0, 0, 5, 1};
      vecs[15] = '{"sw_no_gnt", 0, 1, 3'b010, 32'h300, 32'h11223344, -1, -1, 0, 0,
                   1, 0, 4'b1111, 32'h11223344, 9, 1};
      vecs[16] = '{"lbu_lane2", 1, 0, 3'b100, 32'h106, 0, 0, 0, 0, 32'h00C30000,
                   0, 32'h000000C3, 0, 0, 3, 1};

      rst        = 1'b1;
      memread    = 1'b0;
      memwrite   = 1'b0;
      rw_type    = 3'b000;
      addr       = '0;
      wdata      = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);

      for (int i = 0; i < NVec; i++) run_access(vecs[i]);

      // Reset while waiting for read data: no completion, late rvalid ignored
      memread = 1'b1;
      rw_type = 3'b010;
      addr    = 32'h100;
      @(posedge clk);
      #1 memread = 1'b0;
      @(negedge clk);
      chk("abort_req", {31'h0, mem_req}, 32'h1);
      mem_gnt = 1'b1;
      @(posedge clk);
      #1 mem_gnt = 1'b0;
      chk("abort_wait_stall", {31'h0, stall}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFEF00D;
      chk("abort_req_low", {31'h0, mem_req}, 32'h0);
      @(posedge clk);
      #1 mem_rvalid = 1'b0;
      chk("abort_done", {31'h0, done}, 32'h0);
      chk("abort_rdata", rdata, 32'h0);
      chk("abort_stall", {31'h0, stall}, 32'h0);
      @(posedge clk);
      #1;
      chk("abort_done_late", {31'h0, done}, 32'h0);
      @(negedge clk);

      // Normal operation resumes after the abort
      run_access(vecs[1]);

      chk("scoreboard_drained", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
